// File: rtl/mdc_r2_stage.sv
// Radix-2 DIF stage for an MDC FFT pipeline: butterfly, twiddle multiply
// on the difference path, and delay-commutator reordering for the next stage.
module mdc_r2_stage #(
   parameter int W     = 9,
   parameter int M     = 16,
   parameter int TW    = 8,
   parameter int SCALE = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic                in_sof,
   input  logic                in_inv,
   input  logic signed [W-1:0] in_up_re,
   input  logic signed [W-1:0] in_up_im,
   input  logic signed [W-1:0] in_lo_re,
   input  logic signed [W-1:0] in_lo_im,
   input  logic                ovf_clr,
   output logic                out_valid,
   output logic                out_sof,
   output logic signed [W-1:0] out_up_re,
   output logic signed [W-1:0] out_up_im,
   output logic signed [W-1:0] out_lo_re,
   output logic signed [W-1:0] out_lo_im,
   output logic                ovf
);

   localparam int D   = M / 2;
   localparam int NB  = $clog2(M);
   localparam int SH  = TW - 2;
   localparam int PW  = W + TW + 1;
   localparam int RND = 1 << (TW - 3);
   localparam real PI = 3.14159265358979323846;
   localparam real WS = 1.0 * (1 << (TW - 2));

   localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

   // sign-extend one bit so a sum or difference cannot wrap
   function automatic logic signed [W:0] sx(input logic signed [W-1:0] v);
      return {v[W-1], v};
   endfunction

   function automatic logic ov1(input logic signed [W:0] v);
      return v[W] != v[W-1];
   endfunction

   function automatic logic signed [W-1:0] sat1(input logic signed [W:0] v);
      if (!ov1(v))
         return v[W-1:0];
      return v[W] ? MINV : MAXV;
   endfunction

   // butterfly output: halve (floor) or clamp depending on SCALE
   function automatic logic signed [W-1:0] bf(input logic signed [W:0] v);
      if (SCALE != 0)
         return v[W:1];
      return sat1(v);
   endfunction

   function automatic logic ovfp(input logic signed [PW-1:0] v);
      return v[PW-1:W-1] != {(PW-W+1){v[W-1]}};
   endfunction

   function automatic logic signed [W-1:0] satp(input logic signed [PW-1:0] v);
      if (!ovfp(v))
         return v[W-1:0];
      return v[PW-1] ? MINV : MAXV;
   endfunction

   // ---------------- sample index / inverse latch ----------------
   logic          sof_hit;
   logic [NB-1:0] n_q;
   logic [NB-1:0] n_cur;
   logic          inv_q;
   logic          inv_cur;

   assign sof_hit = in_valid & in_sof;
   assign n_cur   = sof_hit ? '0 : n_q;
   assign inv_cur = sof_hit ? in_inv : inv_q;

   // sample counter restarts on sof; inverse mode captured with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_q   <= '0;
         inv_q <= 1'b0;
      end else if (in_valid) begin
         n_q   <= (n_cur == NB'(M - 1)) ? '0 : n_cur + NB'(1);
         inv_q <= inv_cur;
      end
   end

   // ---------------- butterfly ----------------
   logic signed [W:0] s_re;
   logic signed [W:0] s_im;
   logic signed [W:0] f_re;
   logic signed [W:0] f_im;
   logic              bf_ovf;

   assign s_re = sx(in_up_re) + sx(in_lo_re);
   assign s_im = sx(in_up_im) + sx(in_lo_im);
   assign f_re = sx(in_up_re) - sx(in_lo_re);
   assign f_im = sx(in_up_im) - sx(in_lo_im);

   assign bf_ovf = (SCALE == 0) && in_valid &&
                   (ov1(s_re) || ov1(s_im) || ov1(f_re) || ov1(f_im));

   logic                v1;
   logic                inv1;
   logic [NB-1:0]       n1;
   logic signed [W-1:0] u1_re;
   logic signed [W-1:0] u1_im;
   logic signed [W-1:0] d1_re;
   logic signed [W-1:0] d1_im;

   // butterfly register: sum and difference tagged with index and mode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1    <= 1'b0;
         inv1  <= 1'b0;
         n1    <= '0;
         u1_re <= '0;
         u1_im <= '0;
         d1_re <= '0;
         d1_im <= '0;
      end else begin
         v1 <= in_valid;
         if (in_valid) begin
            inv1  <= inv_cur;
            n1    <= n_cur;
            u1_re <= bf(s_re);
            u1_im <= bf(s_im);
            d1_re <= bf(f_re);
            d1_im <= bf(f_im);
         end
      end
   end

   // ---------------- twiddle ROM ----------------
   logic signed [TW-1:0] rom_re [M];
   logic signed [TW-1:0] rom_im [M];

   for (genvar i = 0; i < M; i++) begin : g_rom
      localparam real A  = PI * i / M;
      localparam real CR = WS * $cos(A);
      localparam real CI = -WS * $sin(A);
      localparam int  WR = (CR >= 0.0) ? $rtoi(CR + 0.5) : $rtoi(CR - 0.5);
      localparam int  WI = (CI >= 0.0) ? $rtoi(CI + 0.5) : $rtoi(CI - 0.5);
      assign rom_re[i] = TW'(WR);
      assign rom_im[i] = TW'(WI);
   end

   logic signed [TW-1:0] w_re;
   logic signed [TW-1:0] w_im;

   assign w_re = rom_re[n1];
   assign w_im = inv1 ? -rom_im[n1] : rom_im[n1];

   // ---------------- complex multiply ----------------
   logic signed [PW-1:0] acc_re;
   logic signed [PW-1:0] acc_im;
   logic signed [PW-1:0] sh_re;
   logic signed [PW-1:0] sh_im;
   logic                 mul_ovf;

   assign acc_re = PW'(d1_re) * PW'(w_re) - PW'(d1_im) * PW'(w_im) + PW'(RND);
   assign acc_im = PW'(d1_re) * PW'(w_im) + PW'(d1_im) * PW'(w_re) + PW'(RND);
   assign sh_re  = acc_re >>> SH;
   assign sh_im  = acc_im >>> SH;

   assign mul_ovf = v1 && (ovfp(sh_re) || ovfp(sh_im));

   logic                v2;
   logic [NB-1:0]       n2;
   logic signed [W-1:0] u2_re;
   logic signed [W-1:0] u2_im;
   logic signed [W-1:0] l2_re;
   logic signed [W-1:0] l2_im;

   // multiply/round register: upper sum passes alongside the twiddled diff
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2    <= 1'b0;
         n2    <= '0;
         u2_re <= '0;
         u2_im <= '0;
         l2_re <= '0;
         l2_im <= '0;
      end else begin
         v2 <= v1;
         if (v1) begin
            n2    <= n1;
            u2_re <= u1_re;
            u2_im <= u1_im;
            l2_re <= satp(sh_re);
            l2_im <= satp(sh_im);
         end
      end
   end

   // ---------------- delay commutator ----------------
   logic signed [W-1:0] ldl_re [D];
   logic signed [W-1:0] ldl_im [D];
   logic signed [W-1:0] udl_re [D];
   logic signed [W-1:0] udl_im [D];
   logic                swap;
   logic signed [W-1:0] cu_re;
   logic signed [W-1:0] cu_im;
   logic signed [W-1:0] cl_re;
   logic signed [W-1:0] cl_im;

   assign swap  = n2[NB-1];
   assign cu_re = swap ? ldl_re[D-1] : u2_re;
   assign cu_im = swap ? ldl_im[D-1] : u2_im;
   assign cl_re = swap ? u2_re : ldl_re[D-1];
   assign cl_im = swap ? u2_im : ldl_im[D-1];

   // lower delay: holds the twiddled half until its partner arrives
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < D; i++) begin
            ldl_re[i] <= '0;
            ldl_im[i] <= '0;
         end
      end else if (v2) begin
         ldl_re[0] <= l2_re;
         ldl_im[0] <= l2_im;
         for (int i = 1; i < D; i++) begin
            ldl_re[i] <= ldl_re[i-1];
            ldl_im[i] <= ldl_im[i-1];
         end
      end
   end

   // upper delay: realigns the commutated upper path
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < D; i++) begin
            udl_re[i] <= '0;
            udl_im[i] <= '0;
         end
      end else if (v2) begin
         udl_re[0] <= cu_re;
         udl_im[0] <= cu_im;
         for (int i = 1; i < D; i++) begin
            udl_re[i] <= udl_re[i-1];
            udl_im[i] <= udl_im[i-1];
         end
      end
   end

   // ---------------- priming and output ----------------
   logic [NB-1:0] pcnt;
   logic          primed;

   assign primed = (pcnt == NB'(D));

   // count the first D samples through the commutator; no output for them
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pcnt <= '0;
      else if (v2 && !primed)
         pcnt <= pcnt + NB'(1);
   end

   // output register; data hold while no valid pair is presented
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_up_re <= '0;
         out_up_im <= '0;
         out_lo_re <= '0;
         out_lo_im <= '0;
      end else if (v2 && primed) begin
         out_valid <= 1'b1;
         out_sof   <= (n2 == NB'(D));
         out_up_re <= udl_re[D-1];
         out_up_im <= udl_im[D-1];
         out_lo_re <= cl_re;
         out_lo_im <= cl_im;
      end else begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
      end
   end

   // sticky overflow; a new event wins over a clear in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf <= 1'b0;
      else if (bf_ovf || mul_ovf)
         ovf <= 1'b1;
      else if (ovf_clr)
         ovf <= 1'b0;
   end

endmodule

// File: tb/tb_mdc_r2_stage.sv
// Bench for mdc_r2_stage: two instances (clamping and halving) share one
// random stimulus stream and are scored against a stream-level model.
module tb_mdc_r2_stage;

   localparam int  W  = 9;
   localparam int  M  = 4;
   localparam int  TW = 8;
   localparam int  D  = M / 2;
   localparam int  HN = 4096;
   localparam real PI = 3.14159265358979323846;

   typedef struct {
      int cyc;
      int ur;
      int ui;
      int lr;
      int li;
      bit sof;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic in_sof = 1'b0;
   logic in_inv = 1'b0;
   logic ovf_clr = 1'b0;
   logic signed [W-1:0] a_re = '0;
   logic signed [W-1:0] a_im = '0;
   logic signed [W-1:0] b_re = '0;
   logic signed [W-1:0] b_im = '0;

   logic                ov    [2];
   logic                osof  [2];
   logic signed [W-1:0] our   [2];
   logic signed [W-1:0] oui   [2];
   logic signed [W-1:0] olr   [2];
   logic signed [W-1:0] oli   [2];
   logic                oflag [2];

   int cyc = 0;
   int errs = 0;
   int checks = 0;
   int k = 0;
   int mn = 0;
   bit minv = 1'b0;
   bit movf [2];
   int vcnt = 0;
   int ocnt [2];
   int first_sof = -1;
   int rec = 0;
   int hur [2][HN];
   int hui [2][HN];
   int hlr [2][HN];
   int hli [2][HN];
   int hn  [HN];
   exp_t q0 [$];
   exp_t q1 [$];
   logic [4*W:0] lastv [2];
   logic [4*W:0] reca [$];
   logic [4*W:0] recb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mdc_r2_stage #(.W(W), .M(M), .TW(TW), .SCALE(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
      .in_inv(in_inv), .in_up_re(a_re), .in_up_im(a_im),
      .in_lo_re(b_re), .in_lo_im(b_im), .ovf_clr(ovf_clr),
      .out_valid(ov[0]), .out_sof(osof[0]),
      .out_up_re(our[0]), .out_up_im(oui[0]),
      .out_lo_re(olr[0]), .out_lo_im(oli[0]), .ovf(oflag[0]));

   mdc_r2_stage #(.W(W), .M(M), .TW(TW), .SCALE(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
      .in_inv(in_inv), .in_up_re(a_re), .in_up_im(a_im),
      .in_lo_re(b_re), .in_lo_im(b_im), .ovf_clr(ovf_clr),
      .out_valid(ov[1]), .out_sof(osof[1]),
      .out_up_re(our[1]), .out_up_im(oui[1]),
      .out_lo_re(olr[1]), .out_lo_im(oli[1]), .ovf(oflag[1]));

   task automatic chk(input string nm, input longint act, input longint want);
      checks++;
      if (act != want) begin
         errs++;
         $display("FAIL %s: got %0d want %0d", nm, act, want);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int sat(input int v);
      int hi;
      int lo;
      hi = (1 << (W - 1)) - 1;
      lo = -(1 << (W - 1));
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   function automatic int rnd(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
   endfunction

   function automatic int twr(input int n);
      return rnd(real'(1 << (TW - 2)) * $cos(PI * n / M));
   endfunction

   function automatic int twi(input int n, input bit inv);
      int r;
      r = -rnd(real'(1 << (TW - 2)) * $sin(PI * n / M));
      return inv ? -r : r;
   endfunction

   task automatic bfly(input int s, input int v, output int r, inout bit o);
      if (s == 1) begin
         r = v >>> 1;
      end else begin
         r = sat(v);
         if (r != v) o = 1'b1;
      end
   endtask

   task automatic mulr(input longint acc, output int r, inout bit o);
      longint t;
      t = (acc + (longint'(1) << (TW - 3))) >>> (TW - 2);
      r = sat(int'(t));
      if (longint'(r) != t) o = 1'b1;
   endtask

   task automatic send(input bit sof, input bit inv,
                       input int ar, input int ai, input int br, input int bi);
      int wr;
      int wi;
      in_valid = 1'b1;
      in_sof   = sof;
      in_inv   = inv;
      a_re = W'(ar);
      a_im = W'(ai);
      b_re = W'(br);
      b_im = W'(bi);
      if (sof) begin
         mn   = 0;
         minv = inv;
      end
      wr = twr(mn);
      wi = twi(mn, minv);
      hn[k] = mn;
      for (int s = 0; s < 2; s++) begin
         int ur, ui, dr, di, lr, li;
         bit o;
         exp_t e;
         o = 1'b0;
         bfly(s, ar + br, ur, o);
         bfly(s, ai + bi, ui, o);
         bfly(s, ar - br, dr, o);
         bfly(s, ai - bi, di, o);
         mulr(longint'(dr) * wr - longint'(di) * wi, lr, o);
         mulr(longint'(dr) * wi + longint'(di) * wr, li, o);
         if (o) movf[s] = 1'b1;
         hur[s][k] = ur;
         hui[s][k] = ui;
         hlr[s][k] = lr;
         hli[s][k] = li;
         if (k >= D) begin
            e.cyc = cyc + 3;
            e.sof = (mn == D);
            if (hn[k-D] >= D) begin
               e.ur = (k >= 2 * D) ? hlr[s][k-2*D] : 0;
               e.ui = (k >= 2 * D) ? hli[s][k-2*D] : 0;
            end else begin
               e.ur = hur[s][k-D];
               e.ui = hui[s][k-D];
            end
            if (mn >= D) begin
               e.lr = ur;
               e.li = ui;
            end else begin
               e.lr = hlr[s][k-D];
               e.li = hli[s][k-D];
            end
            if (s == 0) q0.push_back(e);
            else q1.push_back(e);
         end
      end
      k++;
      vcnt++;
      mn = (mn + 1) % M;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_inv   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic zframe();
      send(1'b1, 1'b0, 0, 0, 0, 0);
      repeat (M - 1) send(1'b0, 1'b0, 0, 0, 0, 0);
   endtask

   function automatic int rv();
      return int'($urandom_range(0, 511)) - 256;
   endfunction

   task automatic rsend(input bit sof);
      send(sof, 1'b0, rv(), rv(), rv(), rv());
   endtask

   task automatic drain();
      idle(6);
      chk("drain_q0", q0.size(), 0);
      chk("drain_q1", q1.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_out0", {ov[0], osof[0], our[0], oui[0], olr[0], oli[0], oflag[0]}, 0);
      chk("rst_out1", {ov[1], osof[1], our[1], oui[1], olr[1], oli[1], oflag[1]}, 0);
      k = 0;
      mn = 0;
      minv = 1'b0;
      movf[0] = 1'b0;
      movf[1] = 1'b0;
      vcnt = 0;
      ocnt[0] = 0;
      ocnt[1] = 0;
      q0.delete();
      q1.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic chk_ovf(input string nm);
      idle(5);
      chk({nm, "_ovf0"}, oflag[0], movf[0]);
      chk({nm, "_ovf1"}, oflag[1], movf[1]);
   endtask

   task automatic clr_ovf();
      ovf_clr = 1'b1;
      @(posedge clk);
      #1;
      ovf_clr = 1'b0;
      movf[0] = 1'b0;
      movf[1] = 1'b0;
   endtask

   // ---------------- monitor ----------------
   task automatic mon(input int s);
      exp_t e;
      logic [4*W:0] v;
      bit have;
      v = {osof[s], our[s], oui[s], olr[s], oli[s]};
      if (ov[s]) begin
         ocnt[s]++;
         if (s == 0 && osof[0] && first_sof < 0) first_sof = cyc;
         if (s == 0 && rec == 1) reca.push_back(v);
         if (s == 0 && rec == 2) recb.push_back(v);
         have = (s == 0) ? (q0.size() > 0) : (q1.size() > 0);
         checks++;
         if (!have) begin
            errs++;
            $display("FAIL out%0d_unexpected: got output at cycle %0d want none", s, cyc);
         end else begin
            if (s == 0) e = q0.pop_front();
            else e = q1.pop_front();
            if (e.cyc != cyc || e.sof != osof[s] ||
                e.ur != int'(our[s]) || e.ui != int'(oui[s]) ||
                e.lr != int'(olr[s]) || e.li != int'(oli[s])) begin
               errs++;
               $display("FAIL out%0d_slot: got cyc=%0d sof=%0d up=(%0d,%0d) lo=(%0d,%0d) want cyc=%0d sof=%0d up=(%0d,%0d) lo=(%0d,%0d)",
                        s, cyc, osof[s], our[s], oui[s], olr[s], oli[s],
                        e.cyc, e.sof, e.ur, e.ui, e.lr, e.li);
            end
         end
      end else begin
         chk($sformatf("out%0d_hold", s), v, lastv[s]);
      end
      lastv[s] = {1'b0, v[4*W-1:0]};
   endtask

   always @(negedge clk) begin
      if (rst) begin
         lastv[0] = '0;
         lastv[1] = '0;
      end else begin
         mon(0);
         mon(1);
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   int c0;
   int gd [3*M][4];
   bit ginv [3];
   int mism;

   initial begin
      movf[0] = 1'b0;
      movf[1] = 1'b0;
      ocnt[0] = 0;
      ocnt[1] = 0;
      repeat (3) @(posedge clk);
      #1;
      do_reset();

      // impulse
      first_sof = -1;
      c0 = cyc;
      send(1'b1, 1'b0, 100, 0, 0, 0);
      repeat (3) send(1'b0, 1'b0, 0, 0, 0, 0);
      zframe();
      drain();
      chk("impulse_sof_cyc", first_sof, c0 + D + 3);

      // twiddle, forward then inverse
      send(1'b1, 1'b0, 0, 0, 0, 0);
      send(1'b0, 1'b0, 64, 0, 0, 0);
      repeat (2) send(1'b0, 1'b0, 0, 0, 0, 0);
      zframe();
      send(1'b1, 1'b1, 0, 0, 0, 0);
      send(1'b0, 1'b0, 64, 0, 0, 0);
      repeat (2) send(1'b0, 1'b0, 0, 0, 0, 0);
      zframe();
      drain();

      // saturation and sticky flag
      clr_ovf();
      send(1'b1, 1'b0, 255, 255, 255, 255);
      repeat (3) send(1'b0, 1'b0, 0, 0, 0, 0);
      zframe();
      chk_ovf("sat_pos");
      clr_ovf();
      chk_ovf("ovf_clr");
      send(1'b1, 1'b0, -256, -256, -256, -256);
      repeat (3) send(1'b0, 1'b0, 0, 0, 0, 0);
      zframe();
      chk_ovf("sat_neg");
      clr_ovf();
      send(1'b1, 1'b0, 0, 0, 0, 0);
      send(1'b0, 1'b0, -128, -128, 128, 128);
      repeat (2) send(1'b0, 1'b0, 0, 0, 0, 0);
      zframe();
      chk_ovf("sat_mul");
      clr_ovf();
      drain();

      // resync mid-frame
      first_sof = -1;
      rsend(1'b1);
      rsend(1'b0);
      c0 = cyc;
      send(1'b1, 1'($urandom_range(0, 1)), rv(), rv(), rv(), rv());
      repeat (3) rsend(1'b0);
      zframe();
      drain();
      chk("resync_sof_cyc", first_sof, c0 + D + 3);

      // reset mid-frame
      rsend(1'b1);
      rsend(1'b0);
      rsend(1'b0);
      do_reset();
      rsend(1'b0);
      rsend(1'b0);
      rsend(1'b1);
      repeat (3) rsend(1'b0);
      zframe();
      drain();

      // gap-free vs gapped run of the same three frames
      for (int i = 0; i < 3 * M; i++)
         for (int j = 0; j < 4; j++)
            gd[i][j] = rv();
      for (int f = 0; f < 3; f++)
         ginv[f] = 1'($urandom_range(0, 1));

      do_reset();
      rec = 1;
      for (int i = 0; i < 3 * M; i++)
         send(i % M == 0, (i % M == 0) ? ginv[i/M] : 1'b0,
              gd[i][0], gd[i][1], gd[i][2], gd[i][3]);
      repeat (D) send(1'b0, 1'b0, 0, 0, 0, 0);
      drain();
      rec = 0;
      chk("gap_cnt_a", ocnt[0], vcnt - D);

      do_reset();
      rec = 2;
      for (int i = 0; i < 3 * M + D; i++) begin
         for (int g = 0; g < 8 && $urandom_range(0, 99) < 40; g++)
            idle(1);
         if (i < 3 * M)
            send(i % M == 0, (i % M == 0) ? ginv[i/M] : 1'b0,
                 gd[i][0], gd[i][1], gd[i][2], gd[i][3]);
         else
            send(1'b0, 1'b0, 0, 0, 0, 0);
      end
      drain();
      rec = 0;
      chk("gap_cnt_b", ocnt[0], vcnt - D);
      chk("gap_len", recb.size(), reca.size());
      mism = 0;
      for (int i = 0; i < reca.size() && i < recb.size(); i++)
         if (reca[i] != recb[i]) mism++;
      chk("gap_seq", mism, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/mdc_r2_stage.md
# mdc_r2_stage

Parametrised radix-2 DIF stage for the multipath delay commutator (MDC) FFT pipeline. It performs butterfly, twiddle multiply on the lower path, and delay-commutator reordering for the next stage. Its generics are data width, butterflies per frame, twiddle precision and scaling mode. Compared with the fixed 9-bit stages, it adds a valid/frame-sync stream, per-frame inverse (IFFT) mode, selectable scaling/saturation and a sticky overflow flag. Instances are chained, M halving per stage, to build 2M·2^k-point MDC FFTs.

## Interface
- W, 9: data width of each real/imag component, signed.
- M, 16: butterflies per frame, power of two, 2..128; reorder delay D = M/2.
- TW, 8: twiddle width, signed, value 1.0 = 2^(TW-2).
- SCALE, 0: 1 = butterfly outputs arithmetic-shifted right by 1; 0 = saturated to W bits.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pair valid; the datapath advances only on valid.
- in_sof  in  1  marks sample 0 of a frame, qualified by in_valid.
- in_inv  in  1  inverse mode (conjugate twiddles), latched at in_valid&in_sof.
- in_up_re, in_up_im  in  W  upper input a[n].
- in_lo_re, in_lo_im  in  W  lower input b[n] = x[n+M].
- ovf_clr  in  1  clears ovf.
- out_valid  out  1  output pair valid.
- out_sof  out  1  marks output slot 0.
- out_up_re, out_up_im, out_lo_re, out_lo_im  out  W  reordered outputs.
- ovf  out  1  sticky saturation flag.

## Operation
- Sample counter n, 0..M-1, advances on in_valid and wraps at M-1→0. in_valid&in_sof forces n=0 for that sample, including mid-frame, where the partial frame is abandoned. After reset n=0.
- Butterfly, full precision W+1: u=a+b, d=a−b. SCALE=1: >>>1 (floor), never saturates. SCALE=0: saturate to [−2^(W-1), 2^(W-1)−1].
- Twiddle ROM, n=0..M-1: w.re=round(2^(TW-2)·cos(πn/M)), w.im=−round(2^(TW-2)·sin(πn/M)). Rounding is half away from zero and the table is fixed at elaboration. When inverse mode is latched, w.im is negated.
- Lower path l = d·w:
  - re = d.re·w.re − d.im·w.im, im = d.re·w.im + d.im·w.re, computed at full width.
  - Add 2^(TW-3), arithmetic shift right by TW-2, saturate to W bits.
  - w0 = 1.0, so l = d exactly.
- Reorder: slot j of each frame is emitted as follows.
  - j<D: up=u[j], lo=u[j+D].
  - j≥D: up=l[j−D], lo=l[j].
  - Implemented as a D-deep lower delay, a commutator (swap when bit log2(D) of the slot index is 1), then a D-deep upper delay. All delays shift only on valid.
- Priming: out_valid stays 0 until D valid samples have entered since rst. After that, each valid input yields exactly one valid output.
- Flush: the last frame's upper half (slots D..M-1) is emitted only as the next D valid samples enter. The user flushes by pushing D zero samples.
- ovf is set by any saturation event on a valid sample. It is cleared by ovf_clr or rst. If set and clear occur in the same cycle, set wins.
- out_sof=1 exactly with slot 0.

## Timing
- Pipeline: butterfly register (+1), multiply/round register (+2), commutator output register (+3).
- Slot j appears 3 cycles after the in_valid cycle carrying the input sample index (j+D) mod M. With gap-free streaming, latency from sample 0 in to slot 0 out is D+3 cycles.
- in_valid gaps stretch the output timing but leave the output sequence unchanged.
- Reset: all outputs 0, out_valid=0, out_sof=0, ovf=0, counters and delay contents 0, inverse latch 0, priming restarted. Reset applies immediately, including mid-frame.
- Data outputs hold their last value while out_valid=0.

## Test plan
Parameters for all scenarios unless noted: W=9, M=4 (D=2), TW=8.

- Reset: assert rst mid-stream → all outputs 0 at once, out_valid low until 2 new valid samples have entered, then slot alignment follows the next in_sof.
- Impulse, SCALE=0: gap-free frame with up=[100,0,0,0], lo=0, followed by a zero frame → out_sof/out_valid 5 cycles after sample 0. Slots: (100,0), (0,0), (100,0), (0,0), all imaginary parts 0.
- Twiddle: up=[0,64,0,0], lo=0. Forward → slot 3 up = (45,−45). With in_inv=1 at sof → (45,45). Slot 1 up = (64,0).
- Saturation:
  - SCALE=0, a=b=255 → u.re=255, ovf=1. ovf_clr → 0.
  - a=b=−256 → u.re=−256.
  - SCALE=1, a=b=255 → u.re=255, ovf stays 0.
  - d=(−256,−256) at n=1 → l saturates, ovf=1.
- Gaps: 3 frames with in_valid randomly low about 40% of cycles → output sequence bit-identical to the gap-free run, output count = valid inputs − 2.
- Resync: in_sof at n=2 → counter restarts, out_sof follows the new frame after 2 more valid samples + 3 cycles.
